// File: rtl/cp0_regfile.sv
// CP0 register bank: commits exception-unit results, services MTC0/MFC0/ERET,
// and runs the Count/Compare timer feeding Cause.TI.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  input  logic        exception_occur,
  input  logic [31:0] exc_we,
  input  logic [4:0]  exc_code,
  input  logic        is_ds,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_badvaddr,
  input  logic [31:0] exc_entryhi,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] entryhi_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_ENTRYHI  = 5'd10;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] EHI_MASK     = 32'hFFFF_E0FF;
  localparam logic [31:0] ST_MASK      = 32'h0000_FF03;

  logic [31:0] badvaddr, count, entryhi, compare, status, epc;
  logic        bd, ti, phase;
  logic [7:0]  ip;
  logic [4:0]  exccode;
  logic        tick, wr_ok, wr_count, wr_compare;
  logic [31:0] count_inc, cause;
  logic        unused_exc_we;

  assign unused_exc_we = ^{exc_we[31:15], exc_we[11], exc_we[9], exc_we[7:0]};

  always_comb begin
    tick       = (COUNT_DIV == 1) ? 1'b1 : phase;
    wr_ok      = mtc0_we & ~exception_occur & ~eret;
    wr_count   = wr_ok && (mtc0_addr == REG_COUNT);
    wr_compare = wr_ok && (mtc0_addr == REG_COMPARE);
    count_inc  = count + 32'd1;
    cause      = {bd, ti, 14'd0, ip, 1'b0, exccode, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr <= '0;
      count    <= '0;
      entryhi  <= '0;
      compare  <= '0;
      status   <= STATUS_RST;
      epc      <= '0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip       <= '0;
      exccode  <= '0;
      phase    <= 1'b0;
    end else begin
      ip[7:2] <= {hw_int[5] | ti, hw_int[4:0]};
      if (exception_occur) begin
        if (exc_we[12]) status[1] <= 1'b1;
        if (exc_we[13]) begin
          exccode <= exc_code;
          if (!status[1]) bd <= is_ds;
        end
        // EPC/BD are frozen while EXL is already set (nested exception)
        if (exc_we[14] && !status[1]) epc <= exc_epc;
        if (exc_we[8])  badvaddr <= exc_badvaddr;
        if (exc_we[10]) entryhi  <= exc_entryhi & EHI_MASK;
      end else if (eret) begin
        status[1] <= 1'b0;
      end else if (mtc0_we) begin
        case (mtc0_addr)
          REG_ENTRYHI: entryhi <= mtc0_wdata & EHI_MASK;
          REG_COMPARE: compare <= mtc0_wdata;
          REG_STATUS:  status  <= (status & ~ST_MASK) | (mtc0_wdata & ST_MASK);
          REG_CAUSE:   ip[1:0] <= mtc0_wdata[9:8];
          REG_EPC:     epc     <= mtc0_wdata;
          default: ;
        endcase
      end

      // A Count write overrides the tick and suppresses the compare check
      if (wr_count) begin
        count <= mtc0_wdata;
        phase <= 1'b0;
      end else begin
        if (tick) count <= count_inc;
        phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
      end

      if (wr_compare) ti <= 1'b0;
      else if (!wr_count && tick && (count_inc == compare)) ti <= 1'b1;
    end
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      REG_BADVADDR: mfc0_rdata = badvaddr;
      REG_COUNT:    mfc0_rdata = count;
      REG_ENTRYHI:  mfc0_rdata = entryhi;
      REG_COMPARE:  mfc0_rdata = compare;
      REG_STATUS:   mfc0_rdata = status;
      REG_CAUSE:    mfc0_rdata = cause;
      REG_EPC:      mfc0_rdata = epc;
      default:      mfc0_rdata = '0;
    endcase
  end

  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign entryhi_o   = entryhi;
  assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: a register-array reference model predicts
// the visible outputs each cycle; a monitor pops and compares on the falling edge.
module tb_cp0_regfile;
  localparam int unsigned   DIV  = 2;
  localparam logic [31:0]   SRST = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn, mtc0_we, exception_occur, is_ds, eret, timer_int_o;
  logic [4:0]  mtc0_addr, mfc0_addr, exc_code;
  logic [31:0] mtc0_wdata, mfc0_rdata, exc_we, exc_epc, exc_badvaddr, exc_entryhi;
  logic [31:0] status_o, cause_o, epc_o, entryhi_o;
  logic [5:0]  hw_int;

  always #5 clk = ~clk;

  cp0_regfile #(.STATUS_RST(SRST), .COUNT_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr),
    .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
    .exception_occur(exception_occur), .exc_we(exc_we), .exc_code(exc_code),
    .is_ds(is_ds), .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr),
    .exc_entryhi(exc_entryhi), .eret(eret), .hw_int(hw_int),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .entryhi_o(entryhi_o), .timer_int_o(timer_int_o)
  );

  typedef struct packed {
    logic        rst_n;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic        exc;
    logic [31:0] exc_we;
    logic [4:0]  code;
    logic        is_ds;
    logic [31:0] epc;
    logic [31:0] badv;
    logic [31:0] ehi;
    logic        eret;
    logic [5:0]  hw;
  } stim_t;

  typedef struct {
    logic [31:0] status, cause, epc, entryhi, rdata;
    logic        ti;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] r [0:31];
  int unsigned m_phase;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] wmask(input logic [4:0] a);
    case (a)
      5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
      5'd10:              return 32'hFFFF_E0FF;
      5'd12:              return 32'h0000_FF03;
      5'd13:              return 32'h0000_0300;
      default:            return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a >= 5'd8 && a <= 5'd14) return r[a];
    return 32'h0;
  endfunction

  task automatic model_step(input stim_t s);
    logic [31:0] o [0:31];
    bit   tick, cw, pw;
    logic ti;
    o = r;
    if (!s.rst_n) begin
      foreach (r[i]) r[i] = 32'h0;
      r[12]   = SRST;
      m_phase = 0;
      return;
    end
    tick = (m_phase == DIV - 1);
    cw = 0; pw = 0;
    if (s.exc) begin
      if (s.exc_we[12]) r[12][1] = 1'b1;
      if (s.exc_we[13]) r[13][6:2] = s.code;
      if (!o[12][1]) begin
        if (s.exc_we[13]) r[13][31] = s.is_ds;
        if (s.exc_we[14]) r[14] = s.epc;
      end
      if (s.exc_we[8])  r[8]  = s.badv;
      if (s.exc_we[10]) r[10] = s.ehi & 32'hFFFF_E0FF;
    end else if (s.eret) begin
      r[12][1] = 1'b0;
    end else if (s.mtc0_we) begin
      r[s.mtc0_addr] = (o[s.mtc0_addr] & ~wmask(s.mtc0_addr)) | (s.mtc0_wdata & wmask(s.mtc0_addr));
      cw = (s.mtc0_addr == 5'd9);
      pw = (s.mtc0_addr == 5'd11);
    end
    if (!cw && tick) r[9] = o[9] + 32'd1;
    m_phase = cw ? 0 : (m_phase + 1) % DIV;
    ti = o[13][30];
    if (pw) ti = 1'b0;
    else if (!cw && tick && (o[9] + 32'd1 == o[11])) ti = 1'b1;
    r[13][30]    = ti;
    r[13][15:10] = {s.hw[5] | o[13][30], s.hw[4:0]};
  endtask

  // Drive one cycle just after a rising edge; the expectation describes what
  // the DUT shows until the next edge.
  task automatic cycle(input stim_t s, input bit chk);
    exp_t e;
    resetn = s.rst_n; mtc0_we = s.mtc0_we; mtc0_addr = s.mtc0_addr;
    mtc0_wdata = s.mtc0_wdata; mfc0_addr = s.mfc0_addr; exception_occur = s.exc;
    exc_we = s.exc_we; exc_code = s.code; is_ds = s.is_ds; exc_epc = s.epc;
    exc_badvaddr = s.badv; exc_entryhi = s.ehi; eret = s.eret; hw_int = s.hw;
    if (chk) begin
      e.status = r[12]; e.cause = r[13]; e.epc = r[14]; e.entryhi = r[10];
      e.rdata = m_read(s.mfc0_addr); e.ti = r[13][30];
      sb.push_back(e);
    end
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.mfc0_addr = 5'd9;
    return s;
  endfunction

  function automatic stim_t mtc0(input logic [4:0] a, input logic [31:0] d);
    stim_t s;
    s = idle();
    s.mtc0_we = 1'b1; s.mtc0_addr = a; s.mtc0_wdata = d;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n      = ($urandom_range(0, 199) != 0);
    s.exc        = ($urandom_range(0, 9) == 0);
    s.eret       = ($urandom_range(0, 7) == 0);
    s.mtc0_we    = ($urandom_range(0, 2) == 0);
    s.mtc0_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
    s.mtc0_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 12));
    s.mfc0_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
    s.exc_we     = $urandom;
    s.code       = 5'($urandom);
    s.is_ds      = 1'($urandom);
    s.epc        = $urandom;
    s.badv       = $urandom;
    s.ehi        = $urandom;
    s.hw         = 6'($urandom);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        check("status_o",    status_o,            e.status);
        check("cause_o",     cause_o,             e.cause);
        check("epc_o",       epc_o,               e.epc);
        check("entryhi_o",   entryhi_o,           e.entryhi);
        check("mfc0_rdata",  mfc0_rdata,          e.rdata);
        check("timer_int_o", {31'd0, timer_int_o}, {31'd0, e.ti});
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    @(posedge clk);
    #1;
    s = idle(); s.rst_n = 1'b0;
    cycle(s, 1'b0);
    repeat (6) cycle(idle(), 1'b1);

    s = idle(); s.exc = 1'b1; s.exc_we = 32'h0000_7000; s.code = 5'h08;
    s.is_ds = 1'b1; s.epc = 32'hBFC0_0100; s.mfc0_addr = 5'd14;
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);
    s.code = 5'h0C; s.is_ds = 1'b0; s.epc = 32'h0000_1234;
    cycle(s, 1'b1);
    s = idle(); s.eret = 1'b1; s.mfc0_addr = 5'd12;
    cycle(s, 1'b1);

    cycle(mtc0(5'd9, 32'd0), 1'b1);
    cycle(mtc0(5'd11, 32'd4), 1'b1);
    repeat (12) cycle(idle(), 1'b1);
    cycle(mtc0(5'd11, 32'd100), 1'b1);
    cycle(idle(), 1'b1);

    cycle(mtc0(5'd12, 32'hFFFF_FFFF), 1'b1);
    cycle(mtc0(5'd8, 32'h5555_AAAA), 1'b1);
    cycle(mtc0(5'd10, 32'hFFFF_FFFF), 1'b1);
    s = idle(); s.mfc0_addr = 5'd8;
    cycle(s, 1'b1);

    s = mtc0(5'd14, 32'h0000_DEAD); s.exc = 1'b1; s.exc_we = 32'h0000_5500;
    s.epc = 32'h0000_BEEF; s.badv = 32'h1357_9BDF; s.ehi = 32'hFFFF_FFFF;
    cycle(s, 1'b1);
    s = mtc0(5'd12, 32'h0000_0000); s.eret = 1'b1;
    cycle(s, 1'b1);
    s = idle(); s.mfc0_addr = 5'd8;
    cycle(s, 1'b1);

    cycle(mtc0(5'd9, 32'hFFFF_FFFD), 1'b1);
    repeat (8) cycle(idle(), 1'b1);

    repeat (3000) cycle(rnd(), 1'b1);
    cycle(idle(), 1'b1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
